// File: rtl/cdc_pkg.sv
// rtl/cdc_pkg.sv - shared constants for clock-domain-crossing blocks
package cdc_pkg;

  // Chain depth limits shared by every CDC block in the library
  localparam int CDC_MIN_STAGES = 2;
  localparam int CDC_MAX_STAGES = 4;

  // Default per-bit value loaded into synchronizer flops on reset
  localparam logic CDC_RESET_VAL = 1'b0;

  // True when a requested chain depth is within the supported range
  function automatic bit cdc_stages_legal(input int stages);
    return (stages >= CDC_MIN_STAGES) && (stages <= CDC_MAX_STAGES);
  endfunction

endpackage

// File: rtl/cdc_edge_detect.sv
// rtl/cdc_edge_detect.sv - registered rise/fall pulse generator for a synchronized level
module cdc_edge_detect
  import cdc_pkg::*;
#(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{CDC_RESET_VAL}}
) (
  input  logic             clk,
  input  logic             rst,
  // Value the synchronized output takes at the coming edge (D of the last chain stage)
  input  logic [WIDTH-1:0] level_next,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  // prev_q tracks the synchronized level, so comparing it against level_next
  // lets the pulses register on the same edge the level itself changes.
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;

  // Next history value and pulse values derived from the incoming level
  always_comb begin
    prev_d = level_next;
    rise_d = level_next & ~prev_q;
    fall_d = ~level_next & prev_q;
  end

  // History and pulse registers; reset history matches the chain reset value
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= RESET_VAL;
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      prev_q <= prev_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: rtl/cdc_synchronizer.sv
// rtl/cdc_synchronizer.sv - multi-flop level synchronizer, optional edge pulses under CDC_SYNC_EDGE_DETECT_EN
module cdc_synchronizer
  import cdc_pkg::*;
#(
  parameter int               STAGES    = 2,
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{CDC_RESET_VAL}}
) (
  input  logic             clk_dest,
  input  logic             rst_dest,
  input  logic [WIDTH-1:0] async_in,
`ifdef CDC_SYNC_EDGE_DETECT_EN
  output logic [WIDTH-1:0] sync_rise,
  output logic [WIDTH-1:0] sync_fall,
`endif
  output logic [WIDTH-1:0] sync_out
);

  if (!cdc_stages_legal(STAGES)) begin : g_bad_stages
    $error("cdc_synchronizer: STAGES must be within 2..4");
  end

  // First two stages carry fixed names so they can be probed hierarchically.
  (* ASYNC_REG = "TRUE", shreg_extract = "no" *) logic [WIDTH-1:0] sync_ff1;
  (* ASYNC_REG = "TRUE", shreg_extract = "no" *) logic [WIDTH-1:0] sync_ff2;

  // stage_lvl[k] is the output of chain stage k
  logic [WIDTH-1:0] stage_lvl [1:STAGES];

  // Front of the chain: async_in goes straight into sync_ff1 with nothing in between
  always_ff @(posedge clk_dest) begin
    if (rst_dest) begin
      sync_ff1 <= RESET_VAL;
      sync_ff2 <= RESET_VAL;
    end else begin
      sync_ff1 <= async_in;
      sync_ff2 <= sync_ff1;
    end
  end

  assign stage_lvl[1] = sync_ff1;
  assign stage_lvl[2] = sync_ff2;

  // Remaining stages, each a plain copy of the one before it
  for (genvar k = 3; k <= STAGES; k++) begin : g_stage
    (* ASYNC_REG = "TRUE", shreg_extract = "no" *) logic [WIDTH-1:0] ff_q;

    // One extra synchronizer stage
    always_ff @(posedge clk_dest) begin
      if (rst_dest) begin
        ff_q <= RESET_VAL;
      end else begin
        ff_q <= stage_lvl[k-1];
      end
    end

    assign stage_lvl[k] = ff_q;
  end

  assign sync_out = stage_lvl[STAGES];

`ifdef CDC_SYNC_EDGE_DETECT_EN
  // The penultimate stage is exactly what sync_out loads next, so pulses
  // line up with the cycle in which sync_out shows the new level.
  cdc_edge_detect #(
    .WIDTH     (WIDTH),
    .RESET_VAL (RESET_VAL)
  ) u_edge_detect (
    .clk        (clk_dest),
    .rst        (rst_dest),
    .level_next (stage_lvl[STAGES-1]),
    .rise       (sync_rise),
    .fall       (sync_fall)
  );
`endif

endmodule

// File: tb/tb_cdc_synchronizer.sv
// tb/tb_cdc_synchronizer.sv - directed self-checking bench for cdc_synchronizer
module tb_cdc_synchronizer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       a_in;
  logic       a_out;
  logic [3:0] b_in;
  logic [3:0] b_out;
`ifdef CDC_SYNC_EDGE_DETECT_EN
  logic       a_rise, a_fall;
  logic [3:0] b_rise, b_fall;
`endif

  int passed = 0;
  int total  = 0;

  cdc_synchronizer #(.STAGES(2), .WIDTH(1)) dut_a (
    .clk_dest (clk),
    .rst_dest (rst),
    .async_in (a_in),
`ifdef CDC_SYNC_EDGE_DETECT_EN
    .sync_rise(a_rise),
    .sync_fall(a_fall),
`endif
    .sync_out (a_out)
  );

  cdc_synchronizer #(.STAGES(3), .WIDTH(4)) dut_b (
    .clk_dest (clk),
    .rst_dest (rst),
    .async_in (b_in),
`ifdef CDC_SYNC_EDGE_DETECT_EN
    .sync_rise(b_rise),
    .sync_fall(b_fall),
`endif
    .sync_out (b_out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Advance to 1 ns after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst  = 1'b1;
    a_in = 1'b0;
    b_in = 4'h0;

    // Reset held across edges at 5 and 15 ns
    tick(); tick();                                   // t=16
    check("rst_a_out", a_out, 1'b0);
    check("rst_a_ff1", dut_a.sync_ff1, 1'b0);
    check("rst_b_out", b_out, 4'h0);
`ifdef CDC_SYNC_EDGE_DETECT_EN
    check("rst_a_rise", a_rise, 1'b0);
    check("rst_a_fall", a_fall, 1'b0);
`endif

    // Inputs go high while reset is still asserted: must be ignored
    a_in = 1'b1;
    b_in = 4'hA;
    tick();                                           // t=26, edge 25 in reset
    check("rst_ign_a_ff1", dut_a.sync_ff1, 1'b0);
    check("rst_ign_a_out", a_out, 1'b0);
    check("rst_ign_b_out", b_out, 4'h0);

    // Release reset; edge 35 is edge 1 of the capture
    rst = 1'b0;
    tick();                                           // t=36
    check("rise_e1_a_ff1", dut_a.sync_ff1, 1'b1);
    check("rise_e1_a_out", a_out, 1'b0);
    check("rise_e1_b_out", b_out, 4'h0);
    tick();                                           // t=46, edge 2
    check("rise_e2_a_ff2", dut_a.sync_ff2, 1'b1);
    check("rise_e2_a_out", a_out, 1'b1);
    check("rise_e2_b_ff2", dut_b.sync_ff2, 4'hA);
    check("rise_e2_b_out", b_out, 4'h0);
`ifdef CDC_SYNC_EDGE_DETECT_EN
    check("rise_e2_a_rise", a_rise, 1'b1);
    check("rise_e2_a_fall", a_fall, 1'b0);
`endif
    tick();                                           // t=56, edge 3
    check("rise_e3_a_out", a_out, 1'b1);
    check("rise_e3_b_out", b_out, 4'hA);
`ifdef CDC_SYNC_EDGE_DETECT_EN
    check("rise_e3_a_rise", a_rise, 1'b0);
    check("rise_e3_b_rise", b_rise, 4'hA);
    check("rise_e3_b_fall", b_fall, 4'h0);
`endif

    // Falling level on A, new pattern on B with mixed rising and falling bits
    a_in = 1'b0;
    b_in = 4'h5;
    tick();                                           // edge 1
    check("fall_e1_a_ff1", dut_a.sync_ff1, 1'b0);
    check("fall_e1_a_out", a_out, 1'b1);
    check("fall_e1_b_out", b_out, 4'hA);
    tick();                                           // edge 2
    check("fall_e2_a_out", a_out, 1'b0);
    check("fall_e2_b_out", b_out, 4'hA);
`ifdef CDC_SYNC_EDGE_DETECT_EN
    check("fall_e2_a_fall", a_fall, 1'b1);
    check("fall_e2_a_rise", a_rise, 1'b0);
`endif
    tick();                                           // edge 3
    check("fall_e3_a_out", a_out, 1'b0);
    check("fall_e3_b_out", b_out, 4'h5);
`ifdef CDC_SYNC_EDGE_DETECT_EN
    check("fall_e3_a_fall", a_fall, 1'b0);
    check("fall_e3_b_rise", b_rise, 4'h5);
    check("fall_e3_b_fall", b_fall, 4'hA);
`endif
    tick();
    check("steady_b_out", b_out, 4'h5);
`ifdef CDC_SYNC_EDGE_DETECT_EN
    check("steady_b_rise", b_rise, 4'h0);
    check("steady_b_fall", b_fall, 4'h0);
`endif

    // Reset pulse for a single edge while a rise is in flight on A
    a_in = 1'b1;
    tick();                                           // edge 1: ff1 captures 1
    check("mid_e1_a_ff1", dut_a.sync_ff1, 1'b1);
    rst = 1'b1;
    tick();                                           // reset edge flushes chain
    check("mid_rst_a_ff1", dut_a.sync_ff1, 1'b0);
    check("mid_rst_a_out", a_out, 1'b0);
    check("mid_rst_b_out", b_out, 4'h0);
    rst = 1'b0;
    tick();                                           // sampling resumes
    check("mid_r1_a_out", a_out, 1'b0);
    check("mid_r1_a_ff1", dut_a.sync_ff1, 1'b1);
`ifdef CDC_SYNC_EDGE_DETECT_EN
    check("mid_r1_a_rise", a_rise, 1'b0);
    check("mid_r1_b_fall", b_fall, 4'h0);
`endif
    tick();
    check("mid_r2_a_out", a_out, 1'b1);
    check("mid_r2_b_out", b_out, 4'h0);
`ifdef CDC_SYNC_EDGE_DETECT_EN
    check("mid_r2_a_rise", a_rise, 1'b1);
`endif
    tick();
    check("mid_r3_b_out", b_out, 4'h5);

    // Pulse train on A: one-cycle high, then back-to-back levels
    a_in = 1'b0;
    tick();                                           // ff1=0, out=1
    a_in = 1'b1;
    tick();                                           // ff1=1, out=0
    check("train_t1_a_out", a_out, 1'b0);
    a_in = 1'b0;
    tick();                                           // ff1=0, out=1
    check("train_t2_a_out", a_out, 1'b1);
`ifdef CDC_SYNC_EDGE_DETECT_EN
    check("train_t2_a_rise", a_rise, 1'b1);
`endif
    tick();                                           // out=0
    check("train_t3_a_out", a_out, 1'b0);
`ifdef CDC_SYNC_EDGE_DETECT_EN
    check("train_t3_a_fall", a_fall, 1'b1);
    check("train_t3_a_rise", a_rise, 1'b0);
`endif
    tick();
    check("train_t4_a_out", a_out, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
